// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor: FSM state encoding
// and the bit-counter width derivation.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of a counter indexing bits 0..width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full-subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - Bin engine, LSB first, one bit per clock with start/busy/done.
// Optional registered zero flag when SERIAL_SUB_ZERO_FLAG_EN is defined.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] D,
    output logic             borrow_out,
    output logic             overflow,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             busy,
    output logic             done
);

    localparam int             CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  res_sr;
    logic [WIDTH-1:0]  res_final;
    logic              br;
    logic [CNT_W-1:0]  cnt;
    logic              d_bit;
    logic              bout_bit;
    logic              last_bit;

    full_subtractor u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (bout_bit)
    );

    assign last_bit  = (cnt == LAST);
    assign res_final = {d_bit, res_sr[WIDTH-1:1]};
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters move right so the cell always sees the current bit at [0];
    // on the final bit [0] holds the operand MSBs, which feed the overflow test.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr       <= '0;
            b_sr       <= '0;
            res_sr     <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            D          <= '0;
            borrow_out <= 1'b0;
            overflow   <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= A;
                        b_sr <= B;
                        br   <= Bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= res_final;
                    br     <= bout_bit;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        D          <= res_final;
                        borrow_out <= bout_bit;
                        overflow   <= (a_sr[0] ^ b_sr[0]) & (d_bit ^ a_sr[0]);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                        zero       <= (res_final == '0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed plan vectors,
// randomized operands against an arithmetic reference, handshake and reset cases.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic [W-1:0] D;
    logic         borrow_out;
    logic         overflow;
    logic         busy;
    logic         done;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic         zero;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .A          (A),
        .B          (B),
        .Bin        (Bin),
        .D          (D),
        .borrow_out (borrow_out),
        .overflow   (overflow),
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        .zero       (zero),
`endif
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer subtraction, wrapped modulo 2^W.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                  output logic [W-1:0] d, output logic bo, output logic ov,
                                  output logic z);
        int diff;
        diff = int'(a) - int'(b) - int'(bin);
        d    = W'(diff & ((1 << W) - 1));
        bo   = (int'(a) < int'(b) + int'(bin));
        ov   = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        z    = (d == '0);
    endfunction

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        @(negedge clk);
        A = a; B = b; Bin = bin; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        Bin = 1'($urandom);
    endtask

    // Edges counted after the accepting edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done && lat < 64);
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({D, borrow_out, overflow, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero", {D, borrow_out, overflow, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle: busy/done got %b expected 00", {busy, done});
        end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        n_cmp++;
        if (zero !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_zero: got %b expected 0", zero);
        end
`endif
    endtask

    task automatic test_directed();
        logic [W-1:0]   va [4] = '{4'd9, 4'd3, 4'd0, 4'd7};
        logic [W-1:0]   vb [4] = '{4'd3, 4'd5, 4'd0, 4'd8};
        logic           vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [W+1:0]   ve [4] = '{{4'h6, 1'b0, 1'b1}, {4'hE, 1'b1, 1'b0},
                                   {4'hF, 1'b1, 1'b0}, {4'hF, 1'b1, 1'b1}};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], vc[i]);
            wait_done(lat);
            n_cmp++;
            if (lat !== W) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d edges expected %0d", i, lat, W);
            end
            n_cmp++;
            if ({D, borrow_out, overflow} !== ve[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d]: got D=%h bo=%b ov=%b expected D=%h bo=%b ov=%b",
                         i, D, borrow_out, overflow, ve[i][W+1:2], ve[i][1], ve[i][0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, ed;
        logic bin, ebo, eov, ez;
        int lat;
        for (int i = 0; i < 30; i++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            if (i % 7 == 0) begin a = '0; b = '1; end
            if (i % 7 == 1) begin a = '1; b = '0; end
            model(a, b, bin, ed, ebo, eov, ez);
            start_op(a, b, bin);
            n_cmp++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_busy[%0d]: got %b expected 1", i, busy);
            end
            wait_done(lat);
            n_cmp++;
            if (lat !== W) begin
                n_fail++;
                $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, W);
            end
            n_cmp++;
            if ({D, borrow_out, overflow} !== {ed, ebo, eov}) begin
                n_fail++;
                $display("FAIL rand_result[%0d] %h-%h-%b: got D=%h bo=%b ov=%b expected D=%h bo=%b ov=%b",
                         i, a, b, bin, D, borrow_out, overflow, ed, ebo, eov);
            end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            n_cmp++;
            if (zero !== ez) begin
                n_fail++;
                $display("FAIL rand_zero[%0d]: got %b expected %b", i, zero, ez);
            end
`endif
            @(posedge clk);
            #1;
            n_cmp++;
            if ({done, busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL rand_pulse[%0d]: done/busy got %b expected 00", i, {done, busy});
            end
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        int cyc;
        int lat;
        start_op(4'd9, 4'd3, 1'b0);
        ndone = 0;
        cyc = 0;
        while (ndone == 0 && cyc < 64) begin
            @(negedge clk);
            start = 1'b1; A = 4'd1; B = 4'd1; Bin = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            if (done) ndone++;
        end
        // Keep start high across the DONE->IDLE edge as well; it must not be taken.
        @(negedge clk);
        @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_busy: got %b expected 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        n_cmp++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL ignore_pulses: got %0d done pulses expected 1", ndone);
        end
        n_cmp++;
        if (D !== 4'd6) begin
            n_fail++;
            $display("FAIL ignore_result: got D=%h expected 6", D);
        end
        start_op(4'd1, 4'd1, 1'b0);
        wait_done(lat);
        n_cmp++;
        if ({lat, D, borrow_out, overflow} !== {W, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_followup: got lat=%0d D=%h bo=%b ov=%b expected lat=%0d D=0 bo=0 ov=0",
                     lat, D, borrow_out, overflow, W);
        end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        n_cmp++;
        if (zero !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_zero: got %b expected 1", zero);
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        int ndone;
        int lat;
        start_op(4'd9, 4'd3, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({D, borrow_out, overflow, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %b expected all zero", {D, borrow_out, overflow, busy, done});
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (W + 3) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL async_no_done: got %0d pulses expected 0", ndone);
        end
        start_op(4'd5, 4'd2, 1'b0);
        wait_done(lat);
        n_cmp++;
        if ({lat, D, borrow_out, overflow} !== {W, 4'd3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_followup: got lat=%0d D=%h bo=%b ov=%b expected lat=%0d D=3 bo=0 ov=0",
                     lat, D, borrow_out, overflow, W);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b, ed;
        logic bin, ebo, eov, ez;
        int cyc;
        int last_done;
        int jobs;
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        A = a; B = b; Bin = bin; start = 1'b1;
        cyc = 0;
        last_done = -1;
        jobs = 0;
        while (jobs < 6 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) begin
                model(a, b, bin, ed, ebo, eov, ez);
                n_cmp++;
                if ({D, borrow_out, overflow} !== {ed, ebo, eov}) begin
                    n_fail++;
                    $display("FAIL b2b_result[%0d]: got D=%h bo=%b ov=%b expected D=%h bo=%b ov=%b",
                             jobs, D, borrow_out, overflow, ed, ebo, eov);
                end
                if (last_done >= 0) begin
                    n_cmp++;
                    if (cyc - last_done !== W + 2) begin
                        n_fail++;
                        $display("FAIL b2b_period[%0d]: got %0d cycles expected %0d", jobs, cyc - last_done, W + 2);
                    end
                end
                last_done = cyc;
                jobs++;
                @(negedge clk);
                a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
                A = a; B = b; Bin = bin;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (jobs !== 6) begin
            n_fail++;
            $display("FAIL b2b_jobs: got %0d completions expected 6", jobs);
        end
        repeat (W + 3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
